// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK bits per clock, LS chunk first.
// Supports cascade-in flags and run-time two's-complement mode.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             cas_e,
    input  logic             cas_l,
    input  logic             cas_g,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flip;
    logic             fE;
    logic             fL;
    logic             fG;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             nE;
    logic             nL;
    logic             nG;
    logic             lastChunk;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (start) stateNext = RUN;
            RUN:  if (lastChunk) stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start;
    end

    // Operands shift right each cycle so the current chunk is always at bit 0.
    always_comb begin
        ca        = opA[CHUNK-1:0];
        cb        = opB[CHUNK-1:0];
        lastChunk = (cnt == CW'(N - 1));
        nE        = fE;
        nL        = fL;
        nG        = fG;
        if (ca != cb) begin
            nE = 1'b0;
            nL = (ca < cb);
            nG = (ca > cb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opA  <= '0;
            opB  <= '0;
            flip <= 1'b0;
            fE   <= 1'b0;
            fL   <= 1'b0;
            fG   <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
            gt   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opA  <= a;
                opB  <= b;
                flip <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                fE   <= cas_e;
                fL   <= cas_l;
                fG   <= cas_g;
                cnt  <= '0;
            end else if (state == RUN) begin
                opA <= opA >> CHUNK;
                opB <= opB >> CHUNK;
                fE  <= nE;
                fL  <= nL;
                fG  <= nG;
                cnt <= cnt + CW'(1);
                if (lastChunk) begin
                    // Differing sign bits invert the unsigned ordering.
                    done <= 1'b1;
                    eq   <= nE;
                    lt   <= flip ? nG : nL;
                    gt   <= flip ? nL : nG;
                end
            end
        end
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands. Processes CHUNK bits per clock, least-significant chunk first. Supports ripple cascade inputs and run-time signed (two's-complement) or unsigned mode. Used in datapaths where a full-width single-cycle compare would break timing. Uses a start/busy/done handshake with results held until the next operation.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per clock; 1 <= CHUNK <= WIDTH.
N (localparam), WIDTH/CHUNK, number of chunk cycles per compare.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request a compare; accepted only when busy=0
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accepted start
cas_e  input  1  cascade equal-in from a less-significant stage; sampled on accepted start
cas_l  input  1  cascade less-in; sampled on accepted start
cas_g  input  1  cascade greater-in; sampled on accepted start
busy  output  1  compare in progress
done  output  1  one-cycle pulse: results valid and updated
eq  output  1  A == B (qualified by cascade)
lt  output  1  A < B
gt  output  1  A > B

Behaviour:
- Reset (asynchronous, any time, including mid-compare):
  - state=IDLE; busy, done, eq, lt, gt = 0.
  - Internal operand, flag, mode and counter registers cleared.
- States: IDLE, RUN.
- IDLE:
  - On the edge where start=1, latch a, b, is_signed, and flags e/l/g = cas_e/cas_l/cas_g.
  - Set chunk counter=0 and go to RUN; busy=1 from the next cycle.
  - done deasserts on any edge it is not re-asserted.
- RUN, one edge per chunk i = counter (chunk i = bits [i*CHUNK +: CHUNK]):
  - If ca_i == cb_i (unsigned): flags unchanged.
  - Otherwise: e=0, l=(ca_i<cb_i), g=(ca_i>cb_i). The more-significant chunk overrides earlier flags.
  - counter increments.
- On the edge processing chunk N-1:
  - Register final flags to eq/lt/gt, after sign correction.
  - done=1 and busy=0 in the following cycle; state returns to IDLE.
- Sign correction: if the latched is_signed=1 and a[WIDTH-1] != b[WIDTH-1], swap lt and gt. eq is already 0 in this case.
- Latency: start accepted at edge k produces the result at edge k+N, with done high for the cycle after edge k+N.
- Throughput: one compare every N cycles. A start during the done cycle is accepted (state is IDLE), giving back-to-back operation.
- Start while busy=1 is ignored. Operand and mode inputs are don't-care while busy.
- eq/lt/gt hold their last result until the next done and do not change during RUN.
- Counter width is max(1, clog2(N)). For N=1 the FSM still passes through one RUN cycle, so latency is 1.
- Cascade inputs pass through unchecked:
  - If all chunks are equal, outputs equal the sampled cascade flags, including illegal combinations.
  - cas_e=0 with no cascade or chunk difference gives eq=lt=gt=0.
- Exactly one of eq/lt/gt is 1 whenever the cascade inputs are one-hot.

Test Plan:
1. WIDTH=16, CHUNK=4, unsigned, a=0x1234, b=0x1235, cas_e=1 -> busy high 4 cycles, done pulse 4 cycles after start, lt=1, eq=gt=0.
2. Signed, a=0xFFFF, b=0x0001 -> lt=1. Same operands unsigned -> gt=1. Signed a=0x8000, b=0x7FFF -> lt=1.
3. a=b=0xABCD with cas_e=1 -> eq=1. Same operands with cas_l=1, cas_e=0 -> lt=1. a=0xABCE, b=0xABCD with cas_l=1 -> gt=1 (upper chunk overrides).
4. Handshake:
   - start pulsed at cycles 1 and 2 with different operands -> only the first is computed.
   - start held high during the done cycle -> second compare accepted, second done exactly 4 cycles later.
   - Outputs stable between dones.
5. rst asserted asynchronously 2 cycles into RUN -> busy/done/eq/lt/gt = 0 immediately, no done pulse. Next start after reset gives a correct result.
6. Parameter variants:
   - WIDTH=8, CHUNK=8 (N=1): a=0x80, b=0x7F signed -> lt=1 with 1-cycle latency.
   - WIDTH=12, CHUNK=1: random sweep of 1000 pairs in both modes vs. reference model, latency 12.
